// File: rtl/pixel_adjust_pkg.sv
// -----------------------------------------------------------------------------
// pixel_adjust_pkg
// Shared types and helpers for the pixel_adjust brightness/contrast unit.
//   PA_GAIN_FRAC  : default number of fractional gain bits
//   PA_GAIN_UNITY : gain code meaning 1.0 at the default fraction
//   marker_t      : frame-position markers travelling with each pixel
//   clamp_sat     : saturate a signed value into [0, 2^data_w-1]
// -----------------------------------------------------------------------------
package pixel_adjust_pkg;

  localparam int PA_GAIN_FRAC  = 4;
  localparam int PA_GAIN_UNITY = 1 << PA_GAIN_FRAC;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } marker_t;

  // Result is 32 bits wide; callers keep the low data_w bits.
  function automatic logic [31:0] clamp_sat(input logic signed [31:0] v,
                                            input int data_w);
    logic signed [31:0] max_v;
    max_v = $signed((32'd1 << data_w) - 32'd1);
    if (v < 0)
      clamp_sat = '0;
    else if (v > max_v)
      clamp_sat = max_v;
    else
      clamp_sat = v;
  endfunction

endpackage

// File: rtl/pixel_adjust_lane.sv
// -----------------------------------------------------------------------------
// pixel_adjust_lane
// One channel of the two-stage datapath.
//   Stage 1: scl = (in*gain + half_lsb) >> GAIN_FRAC   (round half up)
//   Stage 2: out = clamp(scl + offset)
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   en1, en2       : load enables for stage 1 / stage 2 (low = stall)
//   in_data, gain  : stage-1 operands for the pixel being accepted
//   offset         : signed offset belonging to the pixel held in stage 1
//   out_data       : registered, clamped result
//   clip_lo/hi     : (PIXEL_ADJUST_STATS_EN only) result was clamped low/high
// -----------------------------------------------------------------------------
module pixel_adjust_lane
  import pixel_adjust_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en1,
  input  logic                     en2,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [GAIN_W-1:0]        gain,
  input  logic signed [DATA_W:0]   offset,
  output logic [DATA_W-1:0]        out_data
`ifdef PIXEL_ADJUST_STATS_EN
  ,
  output logic                     clip_lo,
  output logic                     clip_hi
`endif
);

  localparam int PROD_W = DATA_W + GAIN_W;
  localparam int SCL_W  = PROD_W - GAIN_FRAC;
  // Two spare bits: one for the sign, one so scl+offset can never wrap.
  localparam int SUM_W  = SCL_W + 2;
  // Half an output LSB; evaluates to zero when there are no fractional bits.
  localparam logic [PROD_W-1:0] RND = PROD_W'((1 << GAIN_FRAC) >> 1);

  logic [PROD_W-1:0]      prod;
  logic [SCL_W-1:0]       scl_q, scl_d;
  logic signed [SUM_W-1:0] sum;
  logic signed [31:0]     sum32;
  logic [DATA_W-1:0]      out_q, out_d;

  always_comb begin
    prod  = PROD_W'(in_data) * PROD_W'(gain) + RND;
    scl_d = en1 ? SCL_W'(prod >> GAIN_FRAC) : scl_q;
    sum   = $signed({2'b00, scl_q}) +
            $signed({{(SUM_W-DATA_W-1){offset[DATA_W]}}, offset});
    sum32 = {{(32-SUM_W){sum[SUM_W-1]}}, sum};
    out_d = en2 ? DATA_W'(clamp_sat(sum32, DATA_W)) : out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '0;
      out_q <= '0;
    end else begin
      scl_q <= scl_d;
      out_q <= out_d;
    end
  end

  assign out_data = out_q;

`ifdef PIXEL_ADJUST_STATS_EN
  localparam logic signed [SUM_W-1:0] MAX_S =
    $signed({{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}});

  logic clip_lo_q, clip_lo_d, clip_hi_q, clip_hi_d;

  always_comb begin
    clip_lo_d = en2 ? (sum < 0)     : clip_lo_q;
    clip_hi_d = en2 ? (sum > MAX_S) : clip_hi_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_lo_q <= 1'b0;
      clip_hi_q <= 1'b0;
    end else begin
      clip_lo_q <= clip_lo_d;
      clip_hi_q <= clip_hi_d;
    end
  end

  assign clip_lo = clip_lo_q;
  assign clip_hi = clip_hi_q;
`endif

endmodule

// File: rtl/pixel_adjust.sv
// -----------------------------------------------------------------------------
// pixel_adjust
// Streaming per-pixel brightness/contrast: out = clamp(round(in*gain)+offset)
// per channel, two pipeline stages, 1 pixel/clk, frame markers alongside data.
// Gain/offset are double-buffered: cfg_update loads the shadow copy, and the
// active copy follows the shadow when the start-of-frame pixel is accepted.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data        : input pixel stream (channel 0 in LSBs)
//   m_valid/m_ready/m_data        : output pixel stream
//   m_sof/m_eol/m_eof             : markers of the output pixel
//   cfg_gain/cfg_offset/cfg_update: pending gain (unsigned), offset (signed),
//                                   one-cycle load strobe
// Optional macro PIXEL_ADJUST_STATS_EN adds clip_lo_cnt, clip_hi_cnt and
// stats_valid: per-frame counts of clamped samples, published at EOF output.
// -----------------------------------------------------------------------------
module pixel_adjust
  import pixel_adjust_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CHANNELS  = 1,
  parameter int IMG_W     = 410,
  parameter int IMG_H     = 361,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = PA_GAIN_FRAC
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*DATA_W-1:0]   s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CHANNELS*DATA_W-1:0]   m_data,
  output logic                         m_sof,
  output logic                         m_eol,
  output logic                         m_eof,
  input  logic [GAIN_W-1:0]            cfg_gain,
  input  logic [DATA_W:0]              cfg_offset,
  input  logic                         cfg_update
`ifdef PIXEL_ADJUST_STATS_EN
  ,
  output logic [31:0]                  clip_lo_cnt,
  output logic [31:0]                  clip_hi_cnt,
  output logic                         stats_valid
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [GAIN_W-1:0] GAIN_ONE = (GAIN_FRAC == PA_GAIN_FRAC) ?
    GAIN_W'(PA_GAIN_UNITY) : GAIN_W'(1 << GAIN_FRAC);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [GAIN_W-1:0] shd_gain_q, shd_gain_d, act_gain_q, act_gain_d;
  logic [DATA_W:0]   shd_off_q, shd_off_d, act_off_q, act_off_d;
  logic [DATA_W:0]   off1_q, off1_d;
  logic              v1_q, v1_d, v2_q, v2_d;
  marker_t           mk1_q, mk1_d, mk2_q, mk2_d;
  logic              live_q;

  logic              ready1, ready2, accept, at_eol;
  marker_t           mk_in;
  logic [GAIN_W-1:0] fwd_gain, gain_sel;
  logic [DATA_W:0]   fwd_off, off_sel;

  always_comb begin
    ready2  = !v2_q || m_ready;
    ready1  = !v1_q || ready2;
    // live_q keeps s_ready low until the first clock after reset release.
    s_ready = live_q && ready1;
    accept  = s_valid && s_ready;

    at_eol    = (col_q == CW'(IMG_W - 1));
    mk_in.sof = (col_q == '0) && (row_q == '0);
    mk_in.eol = at_eol;
    mk_in.eof = at_eol && (row_q == RW'(IMG_H - 1));

    // A strobe coinciding with the SOF accept is forwarded past the shadow.
    fwd_gain = cfg_update ? cfg_gain   : shd_gain_q;
    fwd_off  = cfg_update ? cfg_offset : shd_off_q;
    gain_sel = mk_in.sof ? fwd_gain : act_gain_q;
    off_sel  = mk_in.sof ? fwd_off  : act_off_q;

    col_d      = col_q;
    row_d      = row_q;
    shd_gain_d = shd_gain_q;
    shd_off_d  = shd_off_q;
    act_gain_d = act_gain_q;
    act_off_d  = act_off_q;
    v1_d       = v1_q;
    mk1_d      = mk1_q;
    off1_d     = off1_q;
    v2_d       = v2_q;
    mk2_d      = mk2_q;

    if (cfg_update) begin
      shd_gain_d = cfg_gain;
      shd_off_d  = cfg_offset;
    end

    if (accept) begin
      if (mk_in.sof) begin
        act_gain_d = fwd_gain;
        act_off_d  = fwd_off;
      end
      if (at_eol) begin
        col_d = '0;
        row_d = mk_in.eof ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (ready1) begin
      v1_d   = accept;
      mk1_d  = mk_in;
      off1_d = off_sel;
    end
    if (ready2) begin
      v2_d  = v1_q;
      mk2_d = mk1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      shd_gain_q <= GAIN_ONE;
      shd_off_q  <= '0;
      act_gain_q <= GAIN_ONE;
      act_off_q  <= '0;
      off1_q     <= '0;
      v1_q       <= 1'b0;
      mk1_q      <= '0;
      v2_q       <= 1'b0;
      mk2_q      <= '0;
      live_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      shd_gain_q <= shd_gain_d;
      shd_off_q  <= shd_off_d;
      act_gain_q <= act_gain_d;
      act_off_q  <= act_off_d;
      off1_q     <= off1_d;
      v1_q       <= v1_d;
      mk1_q      <= mk1_d;
      v2_q       <= v2_d;
      mk2_q      <= mk2_d;
      live_q     <= 1'b1;
    end
  end

  assign m_valid = v2_q;
  assign m_sof   = mk2_q.sof;
  assign m_eol   = mk2_q.eol;
  assign m_eof   = mk2_q.eof;

`ifdef PIXEL_ADJUST_STATS_EN
  logic [CHANNELS-1:0] clip_lo_v, clip_hi_v;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      pixel_adjust_lane #(
        .DATA_W   (DATA_W),
        .GAIN_W   (GAIN_W),
        .GAIN_FRAC(GAIN_FRAC)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .en1     (ready1),
        .en2     (ready2),
        .in_data (s_data[gi*DATA_W +: DATA_W]),
        .gain    (gain_sel),
        .offset  (off1_q),
        .out_data(m_data[gi*DATA_W +: DATA_W])
`ifdef PIXEL_ADJUST_STATS_EN
        ,
        .clip_lo (clip_lo_v[gi]),
        .clip_hi (clip_hi_v[gi])
`endif
      );
    end
  endgenerate

`ifdef PIXEL_ADJUST_STATS_EN
  logic [31:0] lo_acc_q, lo_acc_d, hi_acc_q, hi_acc_d;
  logic [31:0] lo_tot_q, lo_tot_d, hi_tot_q, hi_tot_d;
  logic [31:0] lo_inc, hi_inc;
  logic        stats_valid_q, stats_valid_d;

  always_comb begin
    lo_inc = '0;
    hi_inc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lo_inc = lo_inc + 32'(clip_lo_v[i]);
      hi_inc = hi_inc + 32'(clip_hi_v[i]);
    end
    lo_acc_d      = lo_acc_q;
    hi_acc_d      = hi_acc_q;
    lo_tot_d      = lo_tot_q;
    hi_tot_d      = hi_tot_q;
    stats_valid_d = 1'b0;
    if (v2_q && m_ready) begin
      if (mk2_q.eof) begin
        // Totals include the EOF pixel itself; counting restarts at zero.
        lo_tot_d      = lo_acc_q + lo_inc;
        hi_tot_d      = hi_acc_q + hi_inc;
        lo_acc_d      = '0;
        hi_acc_d      = '0;
        stats_valid_d = 1'b1;
      end else begin
        lo_acc_d = lo_acc_q + lo_inc;
        hi_acc_d = hi_acc_q + hi_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_acc_q      <= '0;
      hi_acc_q      <= '0;
      lo_tot_q      <= '0;
      hi_tot_q      <= '0;
      stats_valid_q <= 1'b0;
    end else begin
      lo_acc_q      <= lo_acc_d;
      hi_acc_q      <= hi_acc_d;
      lo_tot_q      <= lo_tot_d;
      hi_tot_q      <= hi_tot_d;
      stats_valid_q <= stats_valid_d;
    end
  end

  assign clip_lo_cnt = lo_tot_q;
  assign clip_hi_cnt = hi_tot_q;
  assign stats_valid = stats_valid_q;
`endif

endmodule

// File: tb/tb_pixel_adjust.sv
// -----------------------------------------------------------------------------
// tb_pixel_adjust
// Self-checking bench for pixel_adjust. A reference model computes each
// expected pixel from the arithmetic definition (integer math) and the frame
// configuration rules; expectations are queued at input accept and compared
// at output accept. The image is shrunk to 41x36 so several whole frames fit
// in a short run.
// -----------------------------------------------------------------------------
module tb_pixel_adjust;

  localparam int DW = 8;
  localparam int GW = 8;
  localparam int GF = 4;
  localparam int W  = 41;
  localparam int H  = 36;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_sof, m_eol, m_eof;
  logic [GW-1:0] cfg_gain = 8'd16;
  logic [DW:0]   cfg_offset = '0;
  logic          cfg_update = 1'b0;

  always #5 clk = ~clk;

  pixel_adjust #(
    .DATA_W(DW), .CHANNELS(1), .IMG_W(W), .IMG_H(H), .GAIN_W(GW), .GAIN_FRAC(GF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .cfg_gain(cfg_gain), .cfg_offset(cfg_offset), .cfg_update(cfg_update)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sh_g, sh_o, fr_g, fr_o, in_idx, out_idx;
  int cur_g = 16;
  int cur_o = 0;
  int pix[N];
  int obs[N];
  int eol_cnt = 0, sof_cnt = 0, eof_at = -1;
  int first_acc = -1, first_mv = -1;
  bit acc;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_pix(input int x, input int g, input int o);
    int s;
    s = ((x * g + ((1 << GF) >> 1)) >> GF) + o;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic model_reset();
    sb.delete();
    sh_g = 16; sh_o = 0; fr_g = 16; fr_o = 0;
    in_idx = 0; out_idx = 0;
  endtask

  task automatic model_accept(input int d, input bit upd);
    exp_t e;
    if (in_idx == 0) begin
      fr_g = upd ? cur_g : sh_g;
      fr_o = upd ? cur_o : sh_o;
    end
    if (upd) begin sh_g = cur_g; sh_o = cur_o; end
    e.data = 8'(ref_pix(d, fr_g, fr_o));
    e.sof  = (in_idx == 0);
    e.eol  = ((in_idx % W) == W - 1);
    e.eof  = (in_idx == N - 1);
    sb.push_back(e);
    in_idx = (in_idx + 1) % N;
  endtask

  task automatic take_output();
    exp_t e;
    if (sb.size() == 0) begin
      chk("spurious_output", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("data", int'(m_data), int'(e.data));
    chk("sof", int'(m_sof), int'(e.sof));
    chk("eol", int'(m_eol), int'(e.eol));
    chk("eof", int'(m_eof), int'(e.eof));
    obs[out_idx] = int'(m_data);
    if (m_eol) eol_cnt++;
    if (m_sof) sof_cnt++;
    if (m_eof) eof_at = out_idx;
    out_idx = (out_idx + 1) % N;
  endtask

  // One clock: drive after the falling edge, observe handshakes 1 ns later.
  task automatic cycle(input bit sv, input int d, input bit mr, input bit upd,
                       output bit accepted);
    @(negedge clk);
    s_valid = sv; s_data = 8'(d); m_ready = mr; cfg_update = upd;
    cfg_gain = 8'(cur_g); cfg_offset = 9'(cur_o);
    #1;
    accepted = s_valid && s_ready;
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (m_valid && m_ready) take_output();
    if (accepted) begin
      if (first_acc < 0) first_acc = cyc;
      model_accept(d, upd);
    end else if (upd) begin
      sh_g = cur_g; sh_o = cur_o;
    end
    cyc++;
  endtask

  task automatic cfg(input int g, input int o);
    bit a;
    cur_g = g; cur_o = o;
    cycle(1'b0, 0, 1'b1, 1'b1, a);
  endtask

  task automatic drain();
    bit a;
    int g = 0;
    while (sb.size() > 0 && g < 200) begin
      cycle(1'b0, 0, 1'b1, 1'b0, a);
      g++;
    end
    chk("drain_empty", sb.size(), 0);
    cycle(1'b0, 0, 1'b1, 1'b0, a);
  endtask

  task automatic send_frame(input int npix, input int vp, input int rp,
                            input int upd_at, input int upd_g, input int upd_o,
                            input bit rnd_cfg);
    int i = 0;
    int guard = 0;
    bit a, sv, mr, upd;
    bit done_upd = 1'b0;
    while (i < npix) begin
      sv  = ($urandom_range(99) < vp);
      mr  = ($urandom_range(99) < rp);
      upd = 1'b0;
      if (i == upd_at && !done_upd) begin
        cur_g = upd_g; cur_o = upd_o; upd = 1'b1; done_upd = 1'b1;
      end else if (rnd_cfg && $urandom_range(199) == 0) begin
        cur_g = int'($urandom_range(63));
        cur_o = int'($urandom_range(200)) - 100;
        upd   = 1'b1;
      end
      cycle(sv, pix[i], mr, upd, a);
      if (a) i++;
      guard++;
      if (guard > 50 * N) begin
        chk("frame_timeout", i, npix);
        break;
      end
    end
    $display("frame: %0d pixels sent, gain=%0d offset=%0d, checks=%0d", i, cur_g, cur_o, checks);
  endtask

  task automatic rand_pix();
    for (int i = 0; i < N; i++) pix[i] = int'($urandom_range(255));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_markers", int'({m_sof, m_eol, m_eof}), 0);
    rst_n = 1'b1;
    cycle(1'b0, 0, 1'b1, 1'b0, acc);
    cycle(1'b0, 0, 1'b1, 1'b0, acc);
    chk("ready_after_rst", int'(s_ready), 1);

    // Unity ramp at full rate.
    for (int i = 0; i < N; i++) pix[i] = i % 256;
    send_frame(N, 100, 100, -1, 0, 0, 1'b0);
    drain();
    chk("latency", first_mv - first_acc, 2);
    chk("ramp_7", obs[7], 7);
    chk("ramp_255", obs[255], 255);
    chk("ramp_sof_count", sof_cnt, 1);

    cfg(16, 50);
    rand_pix(); pix[0] = 230; pix[1] = 10;
    send_frame(N, 100, 100, -1, 0, 0, 1'b0);
    drain();
    chk("off_p50_clamp_hi", obs[0], 255);
    chk("off_p50_mid", obs[1], 60);

    cfg(16, -50);
    rand_pix(); pix[0] = 30; pix[1] = 100;
    send_frame(N, 100, 100, -1, 0, 0, 1'b0);
    drain();
    chk("off_m50_clamp_lo", obs[0], 0);
    chk("off_m50_mid", obs[1], 50);

    cfg(24, 0);
    rand_pix(); pix[0] = 3; pix[1] = 200;
    send_frame(N, 100, 100, -1, 0, 0, 1'b0);
    drain();
    chk("gain1p5_round", obs[0], 5);
    chk("gain1p5_sat", obs[1], 255);

    cfg(16, 0);
    rand_pix(); pix[1001] = 50;
    send_frame(N, 100, 100, 1000, 32, 0, 1'b0);
    drain();
    chk("midframe_upd_ignored", obs[1001], 50);
    rand_pix(); pix[2] = 50; pix[3] = 200;
    send_frame(N, 100, 100, -1, 0, 0, 1'b0);
    drain();
    chk("next_frame_doubled", obs[2], 100);
    chk("next_frame_doubled_sat", obs[3], 255);
    rand_pix(); pix[0] = 20;
    send_frame(N, 100, 100, 0, 48, 0, 1'b0);
    drain();
    chk("sof_coincident_upd", obs[0], 60);

    // Random throttling on both sides, random mid-frame config traffic.
    cfg(20, -7);
    eol_cnt = 0; sof_cnt = 0; eof_at = -1;
    rand_pix();
    send_frame(N, 70, 60, -1, 0, 0, 1'b1);
    rand_pix();
    send_frame(N, 70, 60, -1, 0, 0, 1'b1);
    drain();
    chk("eol_count", eol_cnt, 2 * H);
    chk("sof_count", sof_cnt, 2);
    chk("eof_index", eof_at, N - 1);

    // Reset with two pixels held in the stalled pipeline.
    cfg(32, 10);
    rand_pix();
    send_frame(2, 100, 0, -1, 0, 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_s_ready", int'(s_ready), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sof_cnt = 0;
    rand_pix(); pix[0] = 77; pix[1] = 200;
    send_frame(N, 100, 100, -1, 0, 0, 1'b0);
    drain();
    chk("post_rst_unity0", obs[0], 77);
    chk("post_rst_unity1", obs[1], 200);
    chk("post_rst_sof", sof_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
